// File: rtl/path_request_feeder_if.sv
// CPU MMIO read bus plus the request producer handshake of the path request feeder.
// master = CPU/producer side, slave = the feeder itself.
interface path_request_feeder_if #(
    parameter int NODE_W = 5
);
    // CPU load side
    logic              MemRead;
    logic [31:0]       DataAdr;
    logic [31:0]       rd_data;
    logic              rd_hit;
    // Request producer side
    logic              req_valid;
    logic              req_ready;
    logic [NODE_W-1:0] req_start;
    logic [NODE_W-1:0] req_end;

    modport master (
        output MemRead, DataAdr, req_valid, req_start, req_end,
        input  rd_data, rd_hit, req_ready
    );

    modport slave (
        input  MemRead, DataAdr, req_valid, req_start, req_end,
        output rd_data, rd_hit, req_ready
    );
endinterface

// File: rtl/path_request_feeder.sv
// Path request feeder: queues (start,end) node requests from the producer and hands
// them to the path-planning CPU through read-only MMIO registers. Loading END pops the
// head entry and marks the CPU busy until it signals path_done.
module path_request_feeder #(
    parameter int          DEPTH     = 4,
    parameter int          NODE_W    = 5,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    path_request_feeder_if.slave   bus,
    input  logic                   path_done,
    output logic                   cpu_busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [31:0] ADDR_START  = BASE_ADDR;
    localparam logic [31:0] ADDR_END    = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [NODE_W-1:0] start_mem [DEPTH];
    logic [NODE_W-1:0] end_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             underflow_q, underflow_d;
    logic [0:0]       state_q, state_d;

    logic        empty, full;
    logic        hit_start, hit_end, hit_status;
    logic        end_read, push, pop;
    logic [31:0] count_w;
    logic [2:0]  count_sat;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    assign hit_start  = (bus.DataAdr == ADDR_START);
    assign hit_end    = (bus.DataAdr == ADDR_END);
    assign hit_status = (bus.DataAdr == ADDR_STATUS);
    assign bus.rd_hit = hit_start | hit_end | hit_status;

    // A load of END pops only when there is something to pop; on empty it flags underflow.
    assign end_read = bus.MemRead && hit_end;
    assign push     = bus.req_valid && !full;
    assign pop      = end_read && !empty;

    assign bus.req_ready = !full;
    assign cpu_busy      = (state_q == ST_BUSY);

    assign count_w   = 32'(count_q);
    assign count_sat = (count_w > 32'd7) ? 3'd7 : count_w[2:0];

    // Next-state for pointers, occupancy, underflow flag and busy FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        state_d     = state_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (end_read && empty) underflow_d = 1'b1;

        // A pop always starts (or restarts) service; path_done only matters while busy.
        if (pop)                                   state_d = ST_BUSY;
        else if (state_q == ST_BUSY && path_done)  state_d = ST_IDLE;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
            state_q     <= state_d;
        end
    end

    // Request storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; stale entries are masked by count_q.
        if (push) begin
            start_mem[wr_ptr_q] <= bus.req_start;
            end_mem[wr_ptr_q]   <= bus.req_end;
        end
    end

    // Zero-latency read mux for the CPU load path.
    always_comb begin
        bus.rd_data = '0;
        if (hit_start && !empty)
            bus.rd_data = 32'(start_mem[rd_ptr_q]);
        else if (hit_end && !empty)
            bus.rd_data = 32'(end_mem[rd_ptr_q]);
        else if (hit_status)
            bus.rd_data = {23'b0, underflow_q, 3'b0, cpu_busy, count_sat, !empty};
    end
endmodule
